// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one single-ported data memory between the CPU
// load/store port (0) and a secondary master (1). Each access is held on the
// memory bus for MemLatency cycles and completes with a one-cycle ready pulse.
// Optional build macro ARB_ROUND_ROBIN_EN: ties alternate between the ports;
// without it port 0 always wins a tie.
module data_memory_arbiter #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int MemLatency = 1   // 1..15 bus cycles per access
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           req,
  input  logic [1:0]           wr,
  input  logic [AddrWidth-1:0] addr0,
  input  logic [AddrWidth-1:0] addr1,
  input  logic [DataWidth-1:0] wdata0,
  input  logic [DataWidth-1:0] wdata1,
  output logic [1:0]           ready,
  output logic [DataWidth-1:0] rdata,
  output logic                 owner,
  output logic                 busy,
  output logic                 mem_enable,
  output logic                 mem_write,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CntInit = 4'(MemLatency - 1);

  state_t               state, state_nxt;
  logic [3:0]           cnt;
  logic                 last_owner;
  logic                 lat_wr;
  logic [AddrWidth-1:0] lat_addr;
  logic [DataWidth-1:0] lat_wdata;
  logic                 winner;

  // Arbitration: a lone request wins; a tie is resolved by the build policy.
  always_comb begin
    if (req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = ~last_owner;
`else
      winner = 1'b0;
`endif
    end else begin
      winner = req[1];
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  // last_owner is kept up to date in both builds; only alternation reads it.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  // State register plus latched request, down-counter, read data and history;
  // enable low freezes everything in place.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata      <= '0;
    end else if (enable) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner     <= winner;
            lat_wr    <= wr[winner];
            lat_addr  <= winner ? addr1 : addr0;
            lat_wdata <= winner ? wdata1 : wdata0;
            cnt       <= CntInit;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!lat_wr) begin
            rdata <= mem_rdata;
          end
        end
        DONE:    last_owner <= owner;
        default: ;
      endcase
    end
  end

  // Next-state and memory/handshake outputs, decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nxt  = state;
    ready      = 2'b00;
    mem_enable = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (req != 2'b00) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_addr   = lat_addr;
        mem_wdata  = lat_wdata;
        mem_enable = enable;
        // The strobe fires only in the final bus cycle: one write per access.
        mem_write  = enable && lat_wr && (cnt == 4'd0);
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        if (enable) ready = owner ? 2'b10 : 2'b01;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed checks of the data memory arbiter.
// Three instances with MemLatency 1, 3 and 2, each with its own behavioural
// memory and its own stimulus, so every latency scenario runs in one bench.
module tb_data_memory_arbiter;

  localparam int N = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0] reset, enable;
  logic [1:0]   req [N];
  logic [1:0]   wr [N];
  logic [1:0]   ready [N];
  logic [31:0]  addr0 [N], addr1 [N], wdata0 [N], wdata1 [N];
  logic [31:0]  rdata [N], mem_addr [N], mem_wdata [N], mem_rdata [N];
  logic [N-1:0] owner, busy, mem_enable, mem_write;

  logic [31:0]  mem [N][256];
  logic [N-1:0] poke_en;
  logic [7:0]   poke_addr;
  logic [31:0]  poke_data;

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_memory_arbiter #(
      .DataWidth (32),
      .AddrWidth (32),
      .MemLatency(g == 0 ? 1 : (g == 1 ? 3 : 2))
    ) u_dut (
      .clock     (clock),
      .reset     (reset[g]),
      .enable    (enable[g]),
      .req       (req[g]),
      .wr        (wr[g]),
      .addr0     (addr0[g]),
      .addr1     (addr1[g]),
      .wdata0    (wdata0[g]),
      .wdata1    (wdata1[g]),
      .ready     (ready[g]),
      .rdata     (rdata[g]),
      .owner     (owner[g]),
      .busy      (busy[g]),
      .mem_enable(mem_enable[g]),
      .mem_write (mem_write[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );
  end

  // Behavioural memories: synchronous write, combinational read, bench preload.
  always @(posedge clock) begin
    for (int g = 0; g < N; g++) begin
      if (poke_en[g]) mem[g][poke_addr] <= poke_data;
      else if (mem_enable[g] && mem_write[g]) mem[g][mem_addr[g][7:0]] <= mem_wdata[g];
    end
  end

  always_comb begin
    for (int g = 0; g < N; g++) mem_rdata[g] = mem[g][mem_addr[g][7:0]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic poke(input int k, input logic [7:0] a, input logic [31:0] d);
    poke_en    = '0;
    poke_en[k] = 1'b1;
    poke_addr  = a;
    poke_data  = d;
    tick();
    poke_en = '0;
  endtask

  // Raise one port's request, watch the bus until its ready pulse, drop req.
  task automatic access(input int k, input int p, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        output int n, output int en_n, output int wr_n,
                        output int wr_pos, output logic bus_ok);
    if (p == 0) begin addr0[k] = a; wdata0[k] = d; end
    else        begin addr1[k] = a; wdata1[k] = d; end
    wr[k][p]  = w;
    req[k][p] = 1'b1;
    n = 0; en_n = 0; wr_n = 0; wr_pos = 0; bus_ok = 1'b1;
    do begin
      tick();
      n++;
      if (mem_enable[k]) begin
        en_n++;
        if (mem_addr[k] !== a) bus_ok = 1'b0;
        if (w && mem_wdata[k] !== d) bus_ok = 1'b0;
        if (mem_write[k]) begin wr_n++; wr_pos = en_n; end
      end
    end while (!ready[k][p] && n < 40);
    if (!ready[k][p]) check("access_timeout", 64'(ready[k]), 64'(1 << p));
    req[k][p] = 1'b0;
  endtask

  int   n, en_n, wr_n, wr_pos;
  logic bus_ok, seen;
  logic [1:0] exp_grant;

  initial begin
    reset = '1; enable = '1; poke_en = '0; poke_addr = '0; poke_data = '0;
    for (int k = 0; k < N; k++) begin
      req[k] = '0; wr[k] = '0; addr0[k] = '0; addr1[k] = '0; wdata0[k] = '0; wdata1[k] = '0;
    end
    repeat (2) tick();

    // Reset state of every instance.
    for (int k = 0; k < N; k++) begin
      check("rst_ready", 64'(ready[k]), 0);
      check("rst_rdata", 64'(rdata[k]), 0);
      check("rst_owner", 64'(owner[k]), 0);
      check("rst_busy",  64'(busy[k]), 0);
      check("rst_mem",   {mem_enable[k], mem_write[k], mem_addr[k], mem_wdata[k]}, 0);
    end
    reset = '0;
    tick();
    poke(0, 8'h10, 32'hDEADBEEF);
    poke(1, 8'h40, 32'h00000011);
    poke(2, 8'h50, 32'hCAFEF00D);

    // 1: single read, MemLatency=1.
    addr0[0] = 32'h10; wr[0] = 2'b00; req[0] = 2'b01;
    tick();
    check("t1_mem_enable", 64'(mem_enable[0]), 1);
    check("t1_mem_addr",   64'(mem_addr[0]), 64'h10);
    check("t1_mem_write",  64'(mem_write[0]), 0);
    check("t1_busy",       64'(busy[0]), 1);
    check("t1_no_ready",   64'(ready[0]), 0);
    tick();
    check("t1_ready",      64'(ready[0]), 64'b01);
    check("t1_rdata",      64'(rdata[0]), 64'hDEADBEEF);
    check("t1_bus_idle",   64'(mem_enable[0]), 0);
    req[0] = 2'b00;
    tick();
    check("t1_ready_pulse", 64'(ready[0]), 0);
    check("t1_idle",        64'(busy[0]), 0);

    // 2: port 1 write, then port 0 read of the same word.
    access(0, 1, 1'b1, 32'h20, 32'h12345678, n, en_n, wr_n, wr_pos, bus_ok);
    check("t2_wr_latency", 64'(n), 2);
    check("t2_wr_strobes", 64'(wr_n), 1);
    check("t2_wr_bus",     64'(bus_ok), 1);
    check("t2_wr_ready",   64'(ready[0]), 64'b10);
    check("t2_wr_rdata",   64'(rdata[0]), 64'hDEADBEEF);
    tick();
    check("t2_mem_word",   64'(mem[0][8'h20]), 64'h12345678);
    access(0, 0, 1'b0, 32'h20, 32'h0, n, en_n, wr_n, wr_pos, bus_ok);
    check("t2_rd_rdata",   64'(rdata[0]), 64'h12345678);
    check("t2_rd_strobes", 64'(wr_n), 0);
    tick();

    // 3: both ports held; each port drops req after its ready, then re-requests.
    reset[0] = 1'b1; tick(); reset[0] = 1'b0; tick();
    addr0[0] = 32'h10; addr1[0] = 32'h20; wr[0] = 2'b00; req[0] = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_grant = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_grant = 2'b01;
`endif
      n = 0;
      do begin tick(); n++; end while (ready[0] == 2'b00 && n < 20);
      check("t3_grant", 64'(ready[0]), 64'(exp_grant));
      req[0] = req[0] & ~ready[0];
      tick();
      req[0] = 2'b11;
    end
    req[0] = 2'b00;
    repeat (4) tick();

    // 4: MemLatency=3 write.
    access(1, 0, 1'b1, 32'h30, 32'hA5A5A5A5, n, en_n, wr_n, wr_pos, bus_ok);
    check("t4_latency",   64'(n), 4);
    check("t4_en_cycles", 64'(en_n), 3);
    check("t4_strobes",   64'(wr_n), 1);
    check("t4_strobe_at", 64'(wr_pos), 3);
    check("t4_bus",       64'(bus_ok), 1);
    check("t4_ready",     64'(ready[1]), 64'b01);
    tick();
    check("t4_mem_word",  64'(mem[1][8'h30]), 64'hA5A5A5A5);

    // 5: reset in the second ACCESS cycle of a MemLatency=3 write aborts it.
    addr1[1] = 32'h40; wdata1[1] = 32'h55; wr[1] = 2'b10; req[1] = 2'b10;
    tick();
    check("t5_cycle1_write", 64'(mem_write[1]), 0);
    check("t5_cycle1_owner", 64'(owner[1]), 1);
    tick();
    check("t5_cycle2_write", 64'(mem_write[1]), 0);
    reset[1] = 1'b1;
    #1;
    check("t5_rst_bus",   {mem_enable[1], mem_write[1], mem_addr[1], mem_wdata[1]}, 0);
    check("t5_rst_state", {30'd0, busy[1], owner[1], ready[1]}, 0);
    req[1] = 2'b00;
    seen = 1'b0;
    repeat (2) begin tick(); seen |= (ready[1] != 2'b00) || mem_write[1]; end
    reset[1] = 1'b0;
    repeat (4) begin tick(); seen |= (ready[1] != 2'b00) || mem_write[1]; end
    check("t5_no_activity", 64'(seen), 0);
    check("t5_mem_kept",    64'(mem[1][8'h40]), 64'h11);

    // 6: enable low for five edges in the middle of a MemLatency=2 read.
    addr0[2] = 32'h50; wr[2] = 2'b00; req[2] = 2'b01;
    tick();
    n = 1;
    enable[2] = 1'b0;
    #1;
    check("t6_freeze_bus", 64'(mem_enable[2]), 0);
    seen = 1'b0;
    repeat (5) begin
      tick(); n++;
      seen |= mem_enable[2] || mem_write[2] || (ready[2] != 2'b00);
    end
    enable[2] = 1'b1;
    do begin tick(); n++; end while (!ready[2][0] && n < 30);
    check("t6_frozen_quiet", 64'(seen), 0);
    check("t6_latency",      64'(n), 8);
    check("t6_ready",        64'(ready[2]), 64'b01);
    check("t6_rdata",        64'(rdata[2]), 64'hCAFEF00D);
    req[2] = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
